// File: rtl/or3_tt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : or3_tt_pkg
// Description : Shared types and helpers for the OR-gate truth-table
//               sequencer: FSM state encoding, settle counter width and
//               the expected-output (OR-reduce) function.
// Revision    : 1.0 - initial release
// ============================================================================
package or3_tt_pkg;

  // Widest gate the sequencer supports; the helper below is sized for it.
  localparam int MAX_N_IN = 8;

  // Settle counter must hold SETTLE-1 for SETTLE up to 15.
  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Reference model of the gate under test: OR of all inputs.
  // Unused upper bits must be zero.
  function automatic logic or_reduce(input logic [MAX_N_IN-1:0] vec);
    return |vec;
  endfunction

endpackage : or3_tt_pkg
`default_nettype wire

// File: rtl/or3_tt_seq.sv
`default_nettype none
// ============================================================================
// Module      : or3_tt_seq
// Description : Exhaustive truth-table tester for an N_IN-input OR gate.
//               Walks every input vector, holds each for SETTLE cycles,
//               compares the gate output with the expected OR-reduce and
//               reports a saturating mismatch count plus a pass flag.
//               Optional macro OR3_TT_SEQ_FAILCAP_EN adds capture of the
//               first failing vector on fail_vec / fail_vld.
// Revision    : 1.0 - initial release
// ============================================================================
module or3_tt_seq
  import or3_tt_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] abc_o,
  input  logic            y_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt
`ifdef OR3_TT_SEQ_FAILCAP_EN
  ,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_vld
`endif
);

  localparam logic [N_IN-1:0]         c_abc_max     = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]         c_abc_one     = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]           c_err_max     = {(N_IN+1){1'b1}};
  localparam logic [N_IN:0]           c_err_one     = {{N_IN{1'b0}}, 1'b1};
  localparam logic [SETTLE_CNT_W-1:0] c_settle_last = SETTLE_CNT_W'(SETTLE - 1);
  localparam logic [SETTLE_CNT_W-1:0] c_settle_one  = SETTLE_CNT_W'(1);

  state_t                  r_state;
  logic [SETTLE_CNT_W-1:0] r_settle_cnt;
  logic [N_IN-1:0]         r_abc;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic [N_IN:0]           r_err_cnt;
`ifdef OR3_TT_SEQ_FAILCAP_EN
  logic [N_IN-1:0]         r_fail_vec;
  logic                    r_fail_vld;
`endif

  logic [MAX_N_IN-1:0]     w_abc_ext;
  logic                    w_mismatch;
  logic [N_IN:0]           w_err_next;

  // Expected gate output and the mismatch count this CHECK would produce.
  always_comb begin
    w_abc_ext             = '0;
    w_abc_ext[N_IN-1:0]   = r_abc;
    w_mismatch            = (y_i != or_reduce(w_abc_ext));
    w_err_next            = r_err_cnt;
    if (w_mismatch && (r_err_cnt != c_err_max)) begin
      w_err_next = r_err_cnt + c_err_one;
    end
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_abc        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
`ifdef OR3_TT_SEQ_FAILCAP_EN
      r_fail_vec   <= '0;
      r_fail_vld   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_abc <= '0;
          if (start) begin
            r_state      <= ST_DRIVE;
            r_settle_cnt <= '0;
            r_err_cnt    <= '0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
`ifdef OR3_TT_SEQ_FAILCAP_EN
            r_fail_vec   <= '0;
            r_fail_vld   <= 1'b0;
`endif
          end
        end

        ST_DRIVE: begin
          if (r_settle_cnt == c_settle_last) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + c_settle_one;
          end
        end

        ST_CHECK: begin
          r_err_cnt <= w_err_next;
`ifdef OR3_TT_SEQ_FAILCAP_EN
          if (w_mismatch && !r_fail_vld) begin
            r_fail_vec <= r_abc;
            r_fail_vld <= 1'b1;
          end
`endif
          if (r_abc == c_abc_max) begin
            // Last vector: no wrap, finish the run.
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_abc        <= r_abc + c_abc_one;
            r_settle_cnt <= '0;
            r_state      <= ST_DRIVE;
          end
        end

        ST_DONE: begin
          // start is ignored here; vector returns to zero for IDLE.
          r_state <= ST_IDLE;
          r_abc   <= '0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign abc_o   = r_abc;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err_cnt;
`ifdef OR3_TT_SEQ_FAILCAP_EN
  assign fail_vec = r_fail_vec;
  assign fail_vld = r_fail_vld;
`endif

endmodule : or3_tt_seq
`default_nettype wire

// File: doc/or3_tt_seq.md
OR3_TT_SEQ -- requirements
Module: or3_tt_seq

Interface
REQ-001 Parameters: N_IN, default 3, gate input count (legal 2..8).
REQ-002 Parameters: SETTLE, default 1, cycles each vector is held before sampling (legal 1..15).
REQ-003 Port: clk, input, 1, single clock; all state changes on the rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, run request, sampled only in IDLE.
REQ-006 Port: abc_o, output, N_IN, stimulus vector driving the gate inputs (MSB = A).
REQ-007 Port: y_i, input, 1, gate output under test.
REQ-008 Port: busy, output, 1, run in progress.
REQ-009 Port: done, output, 1, one-cycle pulse at end of run.
REQ-010 Port: pass, output, 1, last run had zero mismatches; held until next start.
REQ-011 Port: err_cnt, output, N_IN+1, mismatch count of the last or current run.

Function
REQ-012 FSM states SHALL be IDLE, DRIVE, CHECK and DONE.
REQ-013 IDLE with start=1 at an edge SHALL go to DRIVE: abc_o=0, settle counter=0, err_cnt=0, pass=0.
REQ-014 DRIVE SHALL hold abc_o for exactly SETTLE cycles, then go to CHECK.
REQ-015 CHECK SHALL compare y_i against the OR-reduce of abc_o; on mismatch err_cnt increments, saturating at all-ones.
REQ-016 CHECK with abc_o below all-ones SHALL increment abc_o and return to DRIVE.
REQ-017 CHECK with abc_o equal to all-ones SHALL go to DONE; abc_o does not wrap.
REQ-018 DONE SHALL last one cycle: done=1, busy=0, pass=(err_cnt==0); next state is IDLE; abc_o returns to 0 in IDLE.
REQ-019 busy SHALL be 1 in DRIVE and CHECK only.
REQ-020 Run latency SHALL be 2^N_IN*(SETTLE+1) busy cycles, followed by the done cycle.
REQ-021 start while busy or in DONE SHALL be ignored.
REQ-022 start held high SHALL begin a new run on the first IDLE cycle.
REQ-023 y_i SHALL be sampled only in CHECK; its value in other states has no effect.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, with abc_o=0, busy=0, done=0, pass=0, err_cnt=0, regardless of state.
REQ-025 Reset mid-run SHALL abandon the run, produce no done pulse, and leave pass=0.

Configuration
REQ-026 Macro OR3_TT_SEQ_FAILCAP_EN, when defined, SHALL add output fail_vec (N_IN) and output fail_vld (1).
REQ-027 With OR3_TT_SEQ_FAILCAP_EN defined, the first mismatching abc_o of a run SHALL be latched into fail_vec and fail_vld set to 1.
REQ-028 With OR3_TT_SEQ_FAILCAP_EN defined, fail_vld and fail_vec SHALL be cleared on start and on reset.
REQ-029 Without OR3_TT_SEQ_FAILCAP_EN, those ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package or3_tt_pkg SHALL hold the FSM state enum and the expected-value function (OR-reduce).
REQ-031 The settle counter width constant SHALL also be held in or3_tt_pkg.
REQ-032 The block SHALL contain no sub-module; the existing OR_GATE is instantiated beside it at top level.

Verification
REQ-033 Correct OR_GATE connected, N_IN=3, SETTLE=1, start pulsed -> busy high for 16 cycles, done on cycle 17, pass=1, err_cnt=0.
REQ-034 y_i tied 0 -> err_cnt=7, pass=0; with the macro defined, fail_vec=3'b001 and fail_vld=1.
REQ-035 y_i tied 1 -> err_cnt=1, pass=0; with the macro defined, fail_vec=3'b000.
REQ-036 start pulsed again at busy cycle 5 -> ignored: exactly one done pulse, total latency unchanged.
REQ-037 rst_n low during cycle 9 of a run -> all outputs 0 asynchronously, no done pulse; a new start then completes normally with pass=1.
REQ-038 SETTLE=3, start held high continuously -> back-to-back runs of 32 busy cycles plus 1 done cycle, separated by one IDLE cycle.
